// File: rtl/teamf_alu.sv
// Registered 4-bit ALU (ADD/SUB/AND/XOR) with a one-cycle result strobe.
// Define TEAMF_ALU_FLAGS_EN to add registered carry/borrow and zero flags.
module teamf_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
`ifdef TEAMF_ALU_FLAGS_EN
  output logic             carry,
  output logic             zero,
`endif
  output logic             out_valid
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } opcode_e;

  logic [WIDTH-1:0] result_d, result_q;
  logic             valid_q;

  always_comb begin
    result_d = '0;
    unique case (opcode_e'(op))
      OP_ADD:  result_d = a + b;
      OP_SUB:  result_d = a - b;
      OP_AND:  result_d = a & b;
      OP_XOR:  result_d = a ^ b;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) result_q <= result_d;
    end
  end

  assign q         = result_q;
  assign out_valid = valid_q;

`ifdef TEAMF_ALU_FLAGS_EN
  logic carry_d, carry_q, zero_q;

  // A wrapped sum is smaller than either addend exactly when the add carried out.
  always_comb begin
    carry_d = 1'b0;
    unique case (opcode_e'(op))
      OP_ADD:  carry_d = (result_d < a);
      OP_SUB:  carry_d = (a < b);
      default: carry_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (in_valid) begin
      carry_q <= carry_d;
      zero_q  <= (result_d == '0);
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

endmodule

// File: tb/tb_teamf_alu.sv
// Self-checking bench for teamf_alu: arithmetic reference model checked every
// cycle, directed literal checks, and randomized traffic.
module tb_teamf_alu;

  logic       clk;
  logic       rst_n;
  logic       inValid;
  logic [1:0] opSel;
  logic [3:0] opA;
  logic [3:0] opB;
  logic [3:0] q;
  logic       outValid;
`ifdef TEAMF_ALU_FLAGS_EN
  logic       carry;
  logic       zero;
`endif

  int errCount;
  int checkCount;
  bit compareEn;

  logic [3:0] expQ;
  logic       expV;
  logic       expC;
  logic       expZ;

  teamf_alu #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .op        (opSel),
    .a         (opA),
    .b         (opB),
    .q         (q),
`ifdef TEAMF_ALU_FLAGS_EN
    .carry     (carry),
    .zero      (zero),
`endif
    .out_valid (outValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the opcode meaning.
  function automatic logic [3:0] modelResult(int o, int x, int y);
    int r;
    case (o)
      0:       r = (x + y) % 16;
      1:       r = (x - y + 16) % 16;
      2:       r = x & y;
      default: r = x ^ y;
    endcase
    return r[3:0];
  endfunction

  function automatic logic modelCarry(int o, int x, int y);
    if (o == 0) return (x + y) > 15;
    if (o == 1) return x < y;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ <= 4'h0;
      expV <= 1'b0;
      expC <= 1'b0;
      expZ <= 1'b0;
    end else begin
      expV <= inValid;
      if (inValid) begin
        expQ <= modelResult(int'(opSel), int'(opA), int'(opB));
        expC <= modelCarry(int'(opSel), int'(opA), int'(opB));
        expZ <= (modelResult(int'(opSel), int'(opA), int'(opB)) == 4'h0);
      end
    end
  end

  task automatic checkOutput(string name, logic [3:0] wantQ, logic wantV);
    checkCount++;
    if (q !== wantQ || outValid !== wantV) begin
      errCount++;
      $display("[TB] FAIL %s: q=%h out_valid=%b, expected q=%h out_valid=%b at %0t",
               name, q, outValid, wantQ, wantV, $time);
    end
  endtask

`ifdef TEAMF_ALU_FLAGS_EN
  task automatic checkFlags(string name, logic wantC, logic wantZ);
    checkCount++;
    if (carry !== wantC || zero !== wantZ) begin
      errCount++;
      $display("[TB] FAIL %s: carry=%b zero=%b, expected carry=%b zero=%b at %0t",
               name, carry, zero, wantC, wantZ, $time);
    end
  endtask
`endif

  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("model", expQ, expV);
`ifdef TEAMF_ALU_FLAGS_EN
      checkFlags("modelFlags", expC, expZ);
`endif
    end
  end

  // Drive one cycle of inputs, then return just after the capturing edge.
  task automatic applyStimulus(logic v, logic [1:0] o, logic [3:0] x, logic [3:0] y);
    inValid = v;
    opSel   = o;
    opA     = x;
    opB     = y;
    @(posedge clk);
    #2;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    compareEn  = 1'b0;
    rst_n      = 1'b0;
    inValid    = 1'b1;
    opSel      = 2'b00;
    opA        = 4'h3;
    opB        = 4'h4;
    #1 compareEn = 1'b1;

    // Reset held with a valid request present.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      checkOutput("resetHold", 4'h0, 1'b0);
    end
    inValid = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk);
    #2;

    applyStimulus(1'b1, 2'b00, 4'h7, 4'h5);
    checkOutput("add7_5", 4'hC, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'h0, 4'h0);
    checkOutput("add7_5Hold", 4'hC, 1'b0);

    applyStimulus(1'b1, 2'b00, 4'hF, 4'h1);
    checkOutput("addWrap", 4'h0, 1'b1);
`ifdef TEAMF_ALU_FLAGS_EN
    checkFlags("addWrapFlags", 1'b1, 1'b1);
`endif
    applyStimulus(1'b1, 2'b01, 4'h2, 4'h5);
    checkOutput("sub2_5", 4'hD, 1'b1);
`ifdef TEAMF_ALU_FLAGS_EN
    checkFlags("sub2_5Flags", 1'b1, 1'b0);
`endif
    applyStimulus(1'b1, 2'b01, 4'h0, 4'h1);
    checkOutput("subUnderflow", 4'hF, 1'b1);
    applyStimulus(1'b1, 2'b01, 4'h9, 4'h9);
    checkOutput("subEqual", 4'h0, 1'b1);
    applyStimulus(1'b1, 2'b10, 4'hA, 4'hC);
    checkOutput("andAC", 4'h8, 1'b1);
    applyStimulus(1'b1, 2'b11, 4'hA, 4'hC);
    checkOutput("xorAC", 4'h6, 1'b1);

    // Back-to-back stream.
    applyStimulus(1'b1, 2'b00, 4'h1, 4'h1);
    checkOutput("stream0", 4'h2, 1'b1);
    applyStimulus(1'b1, 2'b01, 4'h8, 4'h3);
    checkOutput("stream1", 4'h5, 1'b1);
    applyStimulus(1'b1, 2'b10, 4'hF, 4'h5);
    checkOutput("stream2", 4'h5, 1'b1);
    applyStimulus(1'b1, 2'b11, 4'hF, 4'h5);
    checkOutput("stream3", 4'hA, 1'b1);

    // Idle cycles with wandering operands must not disturb q.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
      checkOutput("hold", 4'hA, 1'b0);
    end

    // Asynchronous reset mid-cycle after a capture, with a request in flight.
    applyStimulus(1'b1, 2'b00, 4'h6, 4'h6);
    checkOutput("preReset", 4'hC, 1'b1);
    opA   = 4'h1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", 4'h0, 1'b0);
    inValid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    checkOutput("postReset", 4'h0, 1'b0);

    // Randomized traffic, checked each cycle by the model compare.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(1)), 2'($urandom_range(3)),
                    4'($urandom_range(15)), 4'($urandom_range(15)));
    end

    inValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    compareEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/teamf_alu.md
Name: teamf_alu

Overview:
- Small registered 4-bit ALU for the D2 test chip.
- Takes a 2-bit opcode and two 4-bit operands, which make up the chip's 10-bit input bus, and produces a 4-bit result, which is the chip's 4-bit output bus.
- Serves as the post-silicon ATPG target block. Its result is registered so that vector application and strobing are deterministic.

Parameters:
- WIDTH, 4, operand and result width in bits. All vectors in this spec assume 4.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies op/a/b in the current cycle.
- op  input  2  operation select (chip pins A3,A4; A3 = MSB).
- a  input  WIDTH  operand A (chip pins A5..A8; A5 = MSB).
- b  input  WIDTH  operand B (chip pins A9..A12; A9 = MSB).
- q  output  WIDTH  registered result (chip pins Q2..Q5; Q2 = MSB).
- out_valid  output  1  high for exactly one cycle when q holds a new result.

Behaviour:
- Reset:
  - rst_n low asynchronously forces q=0 and out_valid=0, regardless of clk.
  - Outputs remain at these values until the first qualified capture after rst_n deasserts.
  - Release of rst_n takes effect at the next rising edge.
- Opcodes (arithmetic is modulo 2^WIDTH; carry/borrow is discarded in the base build):
  - 00 ADD: q = a + b.
  - 01 SUB: q = a - b (two's complement, wraps).
  - 10 AND: q = a & b.
  - 11 XOR: q = a ^ b.
- Latency and capture:
  - On the rising edge where in_valid=1, the result is computed combinationally from op/a/b and captured into q. out_valid=1 in the following cycle (1-cycle latency).
  - When in_valid=0 at an edge, q holds its previous value and out_valid=0.
  - Back-to-back in_valid is supported at one result per cycle with no stalls. There is no backpressure.
- Boundary conditions:
  - ADD overflow wraps: F+1 = 0.
  - SUB underflow wraps: 0-1 = F.
  - a=b under SUB gives 0.
- Reset mid-operation: an in-flight result is discarded. The next capture requires a new in_valid pulse after rst_n=1.
- X/unknown inputs are not required to be handled. The bench drives known values only.

Optional Feature:
- Macro: TEAMF_ALU_FLAGS_EN.
- When defined, two extra registered outputs exist, updated on the same edge as q and cleared to 0 by reset:
  - carry (1 bit): carry-out of ADD, or borrow of SUB (a < b unsigned); 0 for AND/XOR.
  - zero (1 bit): 1 when the captured result equals 0.
- When undefined, these ports and their logic are absent. q and out_valid behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, op=00, a=3, b=4 and clock toggling -> q=0, out_valid=0 throughout. Assert rst_n low asynchronously mid-cycle after a capture -> q=0 immediately, without waiting for a clock edge.
- ADD: op=00, a=7, b=5, in_valid=1 for one cycle -> next cycle q=C, out_valid=1; the cycle after, out_valid=0 and q stays C. Wrap case: a=F, b=1 -> q=0 (carry=1, zero=1 with flags).
- SUB: op=01, a=2, b=5 -> q=D (borrow/carry=1 with flags). Then a=9, b=9 -> q=0.
- AND/XOR: op=10, a=A, b=C -> q=8. Then op=11, a=A, b=C -> q=6.
- Streaming: four consecutive in_valid cycles with ADD(1,1), SUB(8,3), AND(F,5), XOR(F,5) -> q sequence 2, 5, 5, A on consecutive cycles, out_valid held high for 4 cycles.
- Hold: in_valid=0 while op/a/b change randomly for 10 cycles -> q unchanged, out_valid=0.
